// File: rtl/id_fwd_stage_if.sv
// Bundle of decode-side, register-file, forwarding and ID/EX output signals
// for id_fwd_stage. The stage uses the slave modport; its environment uses master.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both 1. in_valid/in_pc/in_* may change freely while in_ready is 0. Once
// out_valid is 1, the out_* fields stay stable until out_ready is seen high.
interface id_fwd_stage_if #(
    parameter int FWD_PORTS  = 2,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OPER_W     = 8
);
    logic                            flush;
    logic                            in_valid;
    logic                            in_ready;
    logic [31:0]                     in_pc;
    logic [OPER_W-1:0]               in_oper;
    logic                            in_rs1_read;
    logic                            in_rs2_read;
    logic [REG_ADDR_W-1:0]           in_rs1_addr;
    logic [REG_ADDR_W-1:0]           in_rs2_addr;
    logic [DATA_W-1:0]               in_imm;
    logic                            in_wreg_write;
    logic [REG_ADDR_W-1:0]           in_wreg_addr;

    logic [REG_ADDR_W-1:0]           rf_raddr1;
    logic [REG_ADDR_W-1:0]           rf_raddr2;
    logic [DATA_W-1:0]               rf_rdata1;
    logic [DATA_W-1:0]               rf_rdata2;

    logic [FWD_PORTS-1:0]            fwd_write;
    logic [FWD_PORTS*REG_ADDR_W-1:0] fwd_addr;
    logic [FWD_PORTS*DATA_W-1:0]     fwd_data;
    logic [FWD_PORTS-1:0]            fwd_ready;

    logic                            out_valid;
    logic                            out_ready;
    logic [31:0]                     out_pc;
    logic [OPER_W-1:0]               out_oper;
    logic [DATA_W-1:0]               out_op1;
    logic [DATA_W-1:0]               out_op2;
    logic                            out_wreg_write;
    logic [REG_ADDR_W-1:0]           out_wreg_addr;

    modport master (
        output flush, in_valid, in_pc, in_oper, in_rs1_read, in_rs2_read,
               in_rs1_addr, in_rs2_addr, in_imm, in_wreg_write, in_wreg_addr,
               rf_rdata1, rf_rdata2, fwd_write, fwd_addr, fwd_data, fwd_ready,
               out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_oper,
               out_op1, out_op2, out_wreg_write, out_wreg_addr
    );

    modport slave (
        input  flush, in_valid, in_pc, in_oper, in_rs1_read, in_rs2_read,
               in_rs1_addr, in_rs2_addr, in_imm, in_wreg_write, in_wreg_addr,
               rf_rdata1, rf_rdata2, fwd_write, fwd_addr, fwd_data, fwd_ready,
               out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_oper,
               out_op1, out_op2, out_wreg_write, out_wreg_addr
    );
endinterface

// File: rtl/id_fwd_stage.sv
// Decode/operand stage: priority operand forwarding, load-use hazard stall and a
// valid/ready ID/EX register. Define ID_STALL_CNT_EN to add the stall_cnt counter.
module id_fwd_stage #(
    parameter int          FWD_PORTS  = 2,
    parameter int          DATA_W     = 32,
    parameter int          REG_ADDR_W = 5,
    parameter int          OPER_W     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    id_fwd_stage_if.slave bus
`ifdef ID_STALL_CNT_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);

    localparam logic [OPER_W-1:0] OP_NOP = '0;

    typedef struct packed {
        logic              haz;
        logic [DATA_W-1:0] data;
    } opnd_t;

    // Sources are walked oldest to youngest so the youngest match overwrites
    // both the data and the hazard verdict of any older match.
    function automatic opnd_t resolve(
        input logic                            rd,
        input logic [REG_ADDR_W-1:0]           addr,
        input logic [DATA_W-1:0]               rdata,
        input logic [DATA_W-1:0]               imm,
        input logic [FWD_PORTS-1:0]            fw,
        input logic [FWD_PORTS*REG_ADDR_W-1:0] fa,
        input logic [FWD_PORTS*DATA_W-1:0]     fd,
        input logic [FWD_PORTS-1:0]            fr
    );
        opnd_t r;
        r.haz  = 1'b0;
        r.data = '0;
        if (!rd) begin
            r.data = imm;
        end else if (addr != '0) begin
            r.data = rdata;
            for (int k = FWD_PORTS - 1; k >= 0; k--) begin
                if (fw[k] && (fa[k*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
                    r.data = fd[k*DATA_W +: DATA_W];
                    r.haz  = !fr[k];
                end
            end
        end
        return r;
    endfunction

    opnd_t op1_res;
    opnd_t op2_res;
    logic  hazard;
    logic  out_free;
    logic  capture;

    assign bus.rf_raddr1 = bus.in_rs1_addr;
    assign bus.rf_raddr2 = bus.in_rs2_addr;

    always_comb begin
        op1_res = resolve(bus.in_rs1_read, bus.in_rs1_addr, bus.rf_rdata1, bus.in_imm,
                          bus.fwd_write, bus.fwd_addr, bus.fwd_data, bus.fwd_ready);
        op2_res = resolve(bus.in_rs2_read, bus.in_rs2_addr, bus.rf_rdata2, bus.in_imm,
                          bus.fwd_write, bus.fwd_addr, bus.fwd_data, bus.fwd_ready);
    end

    assign hazard       = bus.in_valid & (op1_res.haz | op2_res.haz);
    assign out_free     = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = !bus.flush & !hazard & out_free;
    assign capture      = bus.in_valid & bus.in_ready;

    // Flush wins over capture; a stalled or empty cycle with a free output
    // leaves a bubble because out_valid drops whenever EX drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_pc         <= RESET_PC;
            bus.out_oper       <= OP_NOP;
            bus.out_op1        <= '0;
            bus.out_op2        <= '0;
            bus.out_wreg_write <= 1'b0;
            bus.out_wreg_addr  <= '0;
        end else if (bus.flush) begin
            bus.out_valid      <= 1'b0;
            bus.out_oper       <= OP_NOP;
        end else if (capture) begin
            bus.out_valid      <= 1'b1;
            bus.out_pc         <= bus.in_pc;
            bus.out_oper       <= bus.in_oper;
            bus.out_op1        <= op1_res.data;
            bus.out_op2        <= op2_res.data;
            bus.out_wreg_write <= bus.in_wreg_write;
            bus.out_wreg_addr  <= bus.in_wreg_addr;
        end else if (bus.out_ready) begin
            bus.out_valid      <= 1'b0;
        end
    end

`ifdef ID_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && !bus.flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: forwarding priority, load-use stall, backpressure,
// flush and mid-stream reset, with hand-computed expectations.
module tb_id_fwd_stage;
  localparam int          FWD_PORTS  = 2;
  localparam int          DATA_W     = 32;
  localparam int          REG_ADDR_W = 5;
  localparam int          OPER_W     = 8;
  localparam logic [31:0] RESET_PC   = 32'h0000_1000;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  id_fwd_stage_if #(
    .FWD_PORTS(FWD_PORTS), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .OPER_W(OPER_W)
  ) bus ();

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  id_fwd_stage #(
    .FWD_PORTS(FWD_PORTS), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W),
    .OPER_W(OPER_W), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_oper       = '0;
    bus.in_rs1_read   = 1'b0;
    bus.in_rs2_read   = 1'b0;
    bus.in_rs1_addr   = '0;
    bus.in_rs2_addr   = '0;
    bus.in_imm        = '0;
    bus.in_wreg_write = 1'b0;
    bus.in_wreg_addr  = '0;
    bus.rf_rdata1     = '0;
    bus.rf_rdata2     = '0;
    bus.fwd_write     = '0;
    bus.fwd_addr      = '0;
    bus.fwd_data      = '0;
    bus.fwd_ready     = '1;
    bus.out_ready     = 1'b1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [7:0] oper,
                      input logic r1, input logic [4:0] a1,
                      input logic r2, input logic [4:0] a2,
                      input logic [31:0] imm, input logic ww, input logic [4:0] wa);
    bus.in_valid      = 1'b1;
    bus.in_pc         = pc;
    bus.in_oper       = oper;
    bus.in_rs1_read   = r1;
    bus.in_rs1_addr   = a1;
    bus.in_rs2_read   = r2;
    bus.in_rs2_addr   = a2;
    bus.in_imm        = imm;
    bus.in_wreg_write = ww;
    bus.in_wreg_addr  = wa;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({pfx, "_pc"}, bus.out_pc, RESET_PC);
    check({pfx, "_oper"}, {24'd0, bus.out_oper}, 32'd0);
    check({pfx, "_op1"}, bus.out_op1, 32'd0);
    check({pfx, "_op2"}, bus.out_op2, 32'd0);
    check({pfx, "_wwr"}, {31'd0, bus.out_wreg_write}, 32'd0);
    check({pfx, "_wad"}, {27'd0, bus.out_wreg_addr}, 32'd0);
`ifdef ID_STALL_CNT_EN
    check({pfx, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_reset_values("rst0");
    check("rst0_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // rs1 from register file, rs2 from immediate
    send(32'h100, 8'h05, 1'b1, 5'd3, 1'b0, 5'd0, 32'h10, 1'b1, 5'd7);
    bus.rf_rdata1 = 32'hAA;
    #1;
    check("t1_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t1_raddr1", {27'd0, bus.rf_raddr1}, 32'd3);
    tick();
    check("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t1_op1", bus.out_op1, 32'hAA);
    check("t1_op2", bus.out_op2, 32'h10);
    check("t1_pc", bus.out_pc, 32'h100);
    check("t1_oper", {24'd0, bus.out_oper}, 32'h05);
    check("t1_wad", {27'd0, bus.out_wreg_addr}, 32'd7);

    // both sources match r5: youngest wins; rs2 r9 has no match -> regfile
    send(32'h104, 8'h06, 1'b1, 5'd5, 1'b1, 5'd9, 32'h0, 1'b0, 5'd0);
    bus.rf_rdata1 = 32'h55;
    bus.rf_rdata2 = 32'h99;
    bus.fwd_write = 2'b11;
    bus.fwd_addr  = {5'd5, 5'd5};
    bus.fwd_data  = {32'h22, 32'h11};
    bus.fwd_ready = 2'b11;
    tick();
    check("t2_valid", {31'd0, bus.out_valid}, 32'd1);
    check("t2_op1_young", bus.out_op1, 32'h11);
    check("t2_op2_rf", bus.out_op2, 32'h99);
    check("t2_pc", bus.out_pc, 32'h104);

    // only the older source matches
    bus.in_pc     = 32'h108;
    bus.fwd_write = 2'b10;
    tick();
    check("t3_op1_old", bus.out_op1, 32'h22);

    // r0 reads as zero even with matching sources
    bus.in_pc       = 32'h10C;
    bus.in_rs1_addr = 5'd0;
    bus.fwd_write   = 2'b11;
    bus.fwd_addr    = {5'd0, 5'd0};
    tick();
    check("t4_op1_r0", bus.out_op1, 32'h0);
    check("t4_pc", bus.out_pc, 32'h10C);

    // load-use: youngest source matches rs2 but is not ready for 3 cycles
    send(32'h110, 8'h07, 1'b0, 5'd0, 1'b1, 5'd6, 32'h33, 1'b1, 5'd8);
    bus.fwd_write = 2'b01;
    bus.fwd_addr  = {5'd0, 5'd6};
    bus.fwd_data  = {32'h0, 32'h66};
    bus.fwd_ready = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("haz_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("haz_bubble", {31'd0, bus.out_valid}, 32'd0);
    end
    bus.fwd_ready = 2'b01;
    #1;
    check("haz_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check("haz_cap_valid", {31'd0, bus.out_valid}, 32'd1);
    check("haz_cap_op1", bus.out_op1, 32'h33);
    check("haz_cap_op2", bus.out_op2, 32'h66);
    check("haz_cap_pc", bus.out_pc, 32'h110);
`ifdef ID_STALL_CNT_EN
    check("haz_stall_cnt", stall_cnt, 32'd3);
`endif

    // backpressure: out_ready low for two cycles with a new instruction waiting
    send(32'h200, 8'h09, 1'b0, 5'd0, 1'b0, 5'd0, 32'h44, 1'b0, 5'd0);
    bus.fwd_write = 2'b00;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_pc_hold", bus.out_pc, 32'h110);
      check("bp_op2_hold", bus.out_op2, 32'h66);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    check("bp_cap_pc", bus.out_pc, 32'h200);
    check("bp_cap_op1", bus.out_op1, 32'h44);
    check("bp_cap_op2", bus.out_op2, 32'h44);

    // flush with valid output and valid input: nothing captured
    send(32'h300, 8'h0A, 1'b0, 5'd0, 1'b0, 5'd0, 32'h77, 1'b1, 5'd1);
    bus.flush = 1'b1;
    #1;
    check("fl_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_oper", {24'd0, bus.out_oper}, 32'd0);
    check("fl_pc_kept", bus.out_pc, 32'h200);

    // reset in the middle of traffic
    send(32'h400, 8'h0B, 1'b0, 5'd0, 1'b0, 5'd0, 32'h88, 1'b1, 5'd2);
    tick();
    check("mr_valid_pre", {31'd0, bus.out_valid}, 32'd1);
    send(32'h500, 8'h0C, 1'b0, 5'd0, 1'b0, 5'd0, 32'h99, 1'b1, 5'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    check_reset_values("mr");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
